// File: rtl/seq_divider_restoring_pkg.sv
// Shared types and sizing helpers for the restoring divider.
package seq_divider_restoring_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   // Iteration counter must hold the value W itself.
   function automatic int unsigned count_width(input int unsigned w);
      return clog2(w + 1);
   endfunction

endpackage

// File: rtl/seq_divider_restoring_if.sv
// Start/done request bus between the ALU controller and the divider.
interface seq_divider_restoring_if #(
   parameter int unsigned W = 8
);
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_zero
   );
endinterface

// File: rtl/seq_divider_restoring_adder_rca.sv
// Ripple-carry adder; subtraction is obtained by passing ~y with cin=1.
module adder_rca #(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);
   logic [N:0] c;

   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = cin;
      for (int unsigned i = 0; i < N; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      cout = c[N];
   end
endmodule

// File: rtl/seq_divider_restoring.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock.
module seq_divider_restoring
   import seq_divider_restoring_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input logic                  clk,
   input logic                  rst,
   seq_divider_restoring_if.slave bus
);
   localparam int unsigned CW = count_width(W);

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [W:0]    a_q, a_d;
   logic [W-1:0]  q_q, q_d;
   logic [W-1:0]  m_q, m_d;
   logic [W-1:0]  quotient_q, quotient_d;
   logic [W-1:0]  remainder_q, remainder_d;
   logic          div_zero_q, div_zero_d;

   logic [W:0]    a_sh, trial, a_next;
   logic [W-1:0]  q_next;
   logic          trial_cout;

   assign a_sh = {a_q[W-1:0], q_q[W-1]};

   adder_rca #(.N(W + 1)) u_trial_sub (
      .a    (a_sh),
      .b    (~{1'b0, m_q}),
      .cin  (1'b1),
      .sum  (trial),
      .cout (trial_cout)
   );

   // Negative trial means the divisor did not fit: keep the shifted value.
   assign a_next = trial[W] ? a_sh : trial;
   assign q_next = {q_q[W-2:0], ~trial[W]};

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      a_d         = a_q;
      q_d         = q_q;
      m_d         = m_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      div_zero_d  = div_zero_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (bus.start) begin
               a_d     = '0;
               q_d     = bus.dividend;
               m_d     = bus.divisor;
               count_d = CW'(W);
               if (bus.divisor == '0) begin
                  state_d     = S_DONE;
                  quotient_d  = '1;
                  remainder_d = bus.dividend;
                  div_zero_d  = 1'b1;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            a_d     = a_next;
            q_d     = q_next;
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
               state_d     = S_DONE;
               quotient_d  = q_next;
               remainder_d = a_next[W-1:0];
               div_zero_d  = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q         <= '0;
         q_q         <= '0;
         m_q         <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         div_zero_q  <= 1'b0;
      end else begin
         a_q         <= a_d;
         q_q         <= q_d;
         m_q         <= m_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         div_zero_q  <= div_zero_d;
      end
   end

   assign bus.busy      = (state_q == S_RUN);
   assign bus.done      = (state_q == S_DONE);
   assign bus.quotient  = quotient_q;
   assign bus.remainder = remainder_q;
   assign bus.div_zero  = div_zero_q;
endmodule

// File: tb/tb_seq_divider_restoring.sv
// Self-checking bench for seq_divider_restoring against an arithmetic reference model.
module tb_seq_divider_restoring;
   localparam int unsigned W = 8;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   seq_divider_restoring_if #(.W(W)) bus ();

   seq_divider_restoring #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
      return (b == 0) ? {W{1'b1}} : W'(a / b);
   endfunction

   function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
      return (b == 0) ? a : W'(a % b);
   endfunction

   // Issues one operation, scrambles operands after acceptance, waits for done.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_n,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output logic done_after);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      tick();
      bus.start    = 1'b0;
      bus.dividend = W'($urandom);
      bus.divisor  = W'($urandom);
      lat    = -1;
      busy_n = 0;
      for (int k = 0; k < 40; k++) begin
         if (bus.busy) busy_n++;
         if (bus.done) begin
            lat = k;
            break;
         end
         tick();
      end
      q  = bus.quotient;
      r  = bus.remainder;
      dz = bus.div_zero;
      tick();
      done_after = bus.done;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0;
      bus.dividend = '0;
      bus.divisor = '0;
      repeat (3) tick();
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      n_cmp++; if (bus.quotient !== '0) begin n_err++; $display("FAIL reset_quot got=%0d exp=0", bus.quotient); end
      n_cmp++; if (bus.remainder !== '0) begin n_err++; $display("FAIL reset_rem got=%0d exp=0", bus.remainder); end
      n_cmp++; if (bus.div_zero !== 1'b0) begin n_err++; $display("FAIL reset_dz got=%b exp=0", bus.div_zero); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      logic [W-1:0] av [3] = '{8'd100, 8'd255, 8'd3};
      logic [W-1:0] bv [3] = '{8'd7, 8'd1, 8'd200};
      int lat, busy_n;
      logic [W-1:0] q, r;
      logic dz, da;
      for (int i = 0; i < 3; i++) begin
         run_op(av[i], bv[i], lat, busy_n, q, r, dz, da);
         n_cmp++; if (lat != W) begin n_err++; $display("FAIL basic_latency %0d/%0d got=%0d exp=%0d", av[i], bv[i], lat, W); end
         n_cmp++; if (busy_n != W) begin n_err++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", busy_n, W); end
         n_cmp++; if (q !== ref_q(av[i], bv[i])) begin n_err++; $display("FAIL basic_quot %0d/%0d got=%0d exp=%0d", av[i], bv[i], q, ref_q(av[i], bv[i])); end
         n_cmp++; if (r !== ref_r(av[i], bv[i])) begin n_err++; $display("FAIL basic_rem %0d/%0d got=%0d exp=%0d", av[i], bv[i], r, ref_r(av[i], bv[i])); end
         n_cmp++; if (dz !== 1'b0) begin n_err++; $display("FAIL basic_dz got=%b exp=0", dz); end
         n_cmp++; if (da !== 1'b0) begin n_err++; $display("FAIL basic_done_width got=%b exp=0", da); end
      end
   endtask

   task automatic test_div_zero();
      int lat, busy_n;
      logic [W-1:0] q, r;
      logic dz, da;
      run_op(8'd5, 8'd0, lat, busy_n, q, r, dz, da);
      n_cmp++; if (lat != 0) begin n_err++; $display("FAIL dz_latency got=%0d exp=0", lat); end
      n_cmp++; if (busy_n != 0) begin n_err++; $display("FAIL dz_busy got=%0d exp=0", busy_n); end
      n_cmp++; if (q !== 8'd255) begin n_err++; $display("FAIL dz_quot got=%0d exp=255", q); end
      n_cmp++; if (r !== 8'd5) begin n_err++; $display("FAIL dz_rem got=%0d exp=5", r); end
      n_cmp++; if (dz !== 1'b1) begin n_err++; $display("FAIL dz_flag got=%b exp=1", dz); end
      n_cmp++; if (da !== 1'b0) begin n_err++; $display("FAIL dz_done_width got=%b exp=0", da); end
   endtask

   task automatic test_ignore_start();
      int lat, busy_n;
      logic [W-1:0] q, r;
      logic dz, da;
      bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
      tick();
      bus.start = 1'b0;
      lat = -1;
      for (int k = 0; k < 40; k++) begin
         if (k == 3) begin
            bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 8'd3;
         end else begin
            bus.start = 1'b0;
         end
         if (bus.done) begin
            lat = k;
            break;
         end
         tick();
      end
      bus.start = 1'b0;
      n_cmp++; if (lat != W) begin n_err++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, W); end
      n_cmp++; if (bus.quotient !== 8'd14) begin n_err++; $display("FAIL ignore_quot got=%0d exp=14", bus.quotient); end
      n_cmp++; if (bus.remainder !== 8'd2) begin n_err++; $display("FAIL ignore_rem got=%0d exp=2", bus.remainder); end
      tick();
      run_op(8'd9, 8'd3, lat, busy_n, q, r, dz, da);
      n_cmp++; if (q !== 8'd3) begin n_err++; $display("FAIL ignore_next_quot got=%0d exp=3", q); end
      n_cmp++; if (r !== 8'd0) begin n_err++; $display("FAIL ignore_next_rem got=%0d exp=0", r); end
   endtask

   task automatic test_reset_mid();
      int lat, busy_n, seen;
      logic [W-1:0] q, r;
      logic dz, da;
      bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
      tick();
      bus.start = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
      n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL rstmid_done got=%b exp=0", bus.done); end
      n_cmp++; if (bus.quotient !== '0) begin n_err++; $display("FAIL rstmid_quot got=%0d exp=0", bus.quotient); end
      n_cmp++; if (bus.remainder !== '0) begin n_err++; $display("FAIL rstmid_rem got=%0d exp=0", bus.remainder); end
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         if (bus.done || bus.busy) seen++;
         tick();
      end
      n_cmp++; if (seen != 0) begin n_err++; $display("FAIL rstmid_activity got=%0d exp=0", seen); end
      run_op(8'd50, 8'd6, lat, busy_n, q, r, dz, da);
      n_cmp++; if (q !== 8'd8 || r !== 8'd2) begin n_err++; $display("FAIL rstmid_restart got=%0d r %0d exp=8 r 2", q, r); end
   endtask

   task automatic test_back_to_back();
      int lat1, lat2, pulses;
      logic [W-1:0] q1, r1;
      bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd9;
      tick();
      bus.dividend = 8'd250; bus.divisor = 8'd250;
      pulses = 0;
      lat1 = -1;
      for (int k = 0; k < 40; k++) begin
         if (bus.done) begin
            lat1 = k;
            break;
         end
         tick();
      end
      pulses += (lat1 >= 0) ? 1 : 0;
      q1 = bus.quotient;
      r1 = bus.remainder;
      tick();
      bus.start = 1'b0;
      lat2 = -1;
      for (int k = 0; k < 40; k++) begin
         if (bus.done) begin
            lat2 = k;
            break;
         end
         tick();
      end
      pulses += (lat2 >= 0) ? 1 : 0;
      n_cmp++; if (q1 !== 8'd22 || r1 !== 8'd2) begin n_err++; $display("FAIL b2b_first got=%0d r %0d exp=22 r 2", q1, r1); end
      n_cmp++; if (bus.quotient !== 8'd1 || bus.remainder !== 8'd0) begin n_err++; $display("FAIL b2b_second got=%0d r %0d exp=1 r 0", bus.quotient, bus.remainder); end
      n_cmp++; if (lat2 != W) begin n_err++; $display("FAIL b2b_latency got=%0d exp=%0d", lat2, W); end
      n_cmp++; if (pulses != 2) begin n_err++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
      tick();
   endtask

   task automatic test_random();
      int lat, busy_n, sel;
      logic [W-1:0] a, b, q, r;
      logic dz, da;
      for (int i = 0; i < 1000; i++) begin
         a = W'($urandom);
         sel = $urandom_range(0, 15);
         if (sel == 0) b = '0;
         else if (sel == 1) b = 8'd1;
         else if (sel < 5) b = W'($urandom_range(1, 15));
         else b = W'($urandom);
         run_op(a, b, lat, busy_n, q, r, dz, da);
         n_cmp++; if (q !== ref_q(a, b)) begin n_err++; $display("FAIL rand_quot %0d/%0d got=%0d exp=%0d", a, b, q, ref_q(a, b)); end
         n_cmp++; if (r !== ref_r(a, b)) begin n_err++; $display("FAIL rand_rem %0d/%0d got=%0d exp=%0d", a, b, r, ref_r(a, b)); end
         n_cmp++; if (dz !== (b == 0)) begin n_err++; $display("FAIL rand_dz %0d/%0d got=%b exp=%b", a, b, dz, (b == 0)); end
         n_cmp++; if (lat != ((b == 0) ? 0 : W)) begin n_err++; $display("FAIL rand_latency %0d/%0d got=%0d exp=%0d", a, b, lat, (b == 0) ? 0 : W); end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.dividend = '0;
      bus.divisor = '0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_div_zero();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
